// File: rtl/ksa_shuffle_s_if.sv
// Memory-port and control bundle between the KSA shuffle engine and its sequencer / S-memory.
// Latency: none (wires only).
// Backpressure: none; the engine owns the port whenever selector is high.
interface ksa_shuffle_s_if #(
    parameter int KEY_BYTES = 3
);
    logic                     start;
    logic [8*KEY_BYTES-1:0]   secret_key;
    logic [7:0]               q;
    logic [7:0]               address;
    logic [7:0]               data;
    logic                     wren;
    logic                     selector;
    logic                     finish;

    // Engine side: drives the memory port and status.
    modport master (
        input  start, secret_key, q,
        output address, data, wren, selector, finish
    );

    // Sequencer / memory side.
    modport slave (
        output start, secret_key, q,
        input  address, data, wren, selector, finish
    );
endinterface

// File: rtl/ksa_shuffle_s.sv
// RC4 key-scheduling shuffle over a 256x8 S-memory (j += S[i] + key[i mod KEY_BYTES]; swap S[i],S[j]).
// Latency: finish pulses 1 + 256*(2*RD_LAT+5) cycles after start is taken in IDLE.
// Backpressure: none; start is only looked at in IDLE, pulses while busy are ignored.
// Optional: define KSA_KEY_LATCH_EN to capture secret_key at start instead of reading it live.
module ksa_shuffle_s #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    ksa_shuffle_s_if.master   bus
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, NEXT, DONE
    } state_t;

    state_t                 state;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;
    logic [7:0]             sj;
    logic [KW-1:0]          kidx;     // i mod KEY_BYTES, kept as its own wrapping counter
    logic [LW-1:0]          wcnt;     // read-latency wait counter
    logic [8*KEY_BYTES-1:0] key_src;
    logic [7:0]             key_byte;
    logic [7:0]             j_new;

`ifdef KSA_KEY_LATCH_EN
    logic [8*KEY_BYTES-1:0] key_q;

    // Capture the key when a shuffle is accepted so later key changes cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
        end else if (state == IDLE && bus.start) begin
            key_q <= bus.secret_key;
        end
    end

    assign key_src = key_q;
`else
    assign key_src = bus.secret_key;
`endif

    // Select key byte kidx; byte 0 is the most significant byte of the key.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) begin
                key_byte = key_src[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
    end

    // Next j uses the S[i] value arriving on q during the last read-wait cycle.
    assign j_new = j + bus.q + key_byte;

    // Shuffle sequencer; all memory-port outputs are registered and set on entry to each state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            i            <= '0;
            j            <= '0;
            si           <= '0;
            sj           <= '0;
            kidx         <= '0;
            wcnt         <= '0;
            bus.address  <= '0;
            bus.data     <= '0;
            bus.wren     <= 1'b0;
            bus.selector <= 1'b0;
            bus.finish   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.finish <= 1'b0;
                    if (bus.start) begin
                        i            <= '0;
                        j            <= '0;
                        kidx         <= '0;
                        bus.address  <= '0;
                        bus.selector <= 1'b1;
                        state        <= RD_I;
                    end
                end
                RD_I: begin
                    wcnt  <= '0;
                    state <= WAIT_I;
                end
                WAIT_I: begin
                    if (wcnt == LW'(RD_LAT-1)) begin
                        si          <= bus.q;
                        j           <= j_new;
                        bus.address <= j_new;
                        state       <= RD_J;
                    end else begin
                        wcnt <= wcnt + LW'(1);
                    end
                end
                RD_J: begin
                    wcnt  <= '0;
                    state <= WAIT_J;
                end
                WAIT_J: begin
                    if (wcnt == LW'(RD_LAT-1)) begin
                        sj          <= bus.q;
                        bus.address <= i;
                        bus.data    <= bus.q;
                        bus.wren    <= 1'b1;
                        state       <= WR_I;
                    end else begin
                        wcnt <= wcnt + LW'(1);
                    end
                end
                WR_I: begin
                    // When i==j this rewrites the same cell with its original value.
                    bus.address <= j;
                    bus.data    <= si;
                    state       <= WR_J;
                end
                WR_J: begin
                    bus.wren <= 1'b0;
                    state    <= NEXT;
                end
                NEXT: begin
                    if (i == 8'hFF) begin
                        bus.selector <= 1'b0;
                        bus.finish   <= 1'b1;
                        state        <= DONE;
                    end else begin
                        i           <= i + 8'd1;
                        bus.address <= i + 8'd1;
                        kidx        <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + KW'(1);
                        state       <= RD_I;
                    end
                end
                DONE: begin
                    bus.finish <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_shuffle_s.sv
module tb_ksa_shuffle_s;

    localparam int KB     = 3;
    localparam int RD_LAT = 1;
    localparam int ITER_CYC = 2*RD_LAT + 5;
    localparam int RUN_CYC  = 1 + 256*ITER_CYC;

    logic clk = 1'b0;
    logic reset;

    ksa_shuffle_s_if #(.KEY_BYTES(KB)) bus ();

    ksa_shuffle_s #(.KEY_BYTES(KB), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // S-memory model with RD_LAT read pipeline and a log of every write.
    logic [7:0]  mem     [256];
    logic [7:0]  qpipe   [RD_LAT];
    logic [15:0] wr_log  [1024];
    int          wr_cnt;
    logic        mem_init_req;

    always @(posedge clk) begin
        if (mem_init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
            wr_cnt <= 0;
        end else if (bus.wren) begin
            mem[bus.address] <= bus.data;
            if (wr_cnt < 1024) begin
                wr_log[wr_cnt] <= {bus.address, bus.data};
                wr_cnt <= wr_cnt + 1;
            end
        end
        qpipe[0] <= mem[bus.address];
        for (int k = 1; k < RD_LAT; k++) qpipe[k] <= qpipe[k-1];
    end

    assign bus.q = qpipe[RD_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Software KSA: final S plus the write sequence the engine must issue.
    logic [7:0]  ref_s  [256];
    logic [15:0] ref_wr [512];

    task automatic ref_ksa(input logic [8*KB-1:0] key);
        int jj;
        logic [7:0] t;
        logic [7:0] kb;
        logic [7:0] i8;
        logic [7:0] j8;
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = key[8*(KB-1-(ii % KB)) +: 8];
            jj = (jj + int'(ref_s[ii]) + int'(kb)) % 256;
            i8 = 8'(ii);
            j8 = 8'(jj);
            t  = ref_s[ii];
            ref_wr[2*ii]   = {i8, ref_s[jj]};
            ref_wr[2*ii+1] = {j8, t};
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    task automatic init_mem();
        @(negedge clk);
        mem_init_req = 1'b1;
        @(negedge clk);
        mem_init_req = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        bus.start = 1'b0;
        #12;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One complete shuffle from identity S; optional key change after start and start held high.
    task automatic run_full(input logic [8*KB-1:0] k0, input logic [8*KB-1:0] k1,
                            input bit change, input logic [8*KB-1:0] model_key, input bit hold);
        int  cyc;
        int  gaps;
        bit  viol;
        init_mem();
        ref_ksa(model_key);
        @(negedge clk);
        bus.secret_key = k0;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = hold;
        cyc  = 1;
        gaps = 0;
        viol = 0;
        check("sel_rise", {31'd0, bus.selector}, 32'd1);
        while (!bus.finish && cyc < RUN_CYC + 500) begin
            if (change && cyc == 1) bus.secret_key = k1;
            if (!hold) bus.start = (cyc < RUN_CYC - 100) ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.finish && !bus.selector) gaps++;
            if (bus.selector && bus.secret_key != k0) viol = 1;
        end
        check("finish_lat", cyc, RUN_CYC);
        check("sel_busy", gaps, 0);
        check("sel_done", {31'd0, bus.selector}, 32'd0);
        check("wr_count", wr_cnt, 512);
        for (int k = 0; k < 512; k++) check($sformatf("wr%0d", k), {16'd0, wr_log[k]}, {16'd0, ref_wr[k]});
        for (int k = 0; k < 256; k++) check($sformatf("S%0d", k), {24'd0, mem[k]}, {24'd0, ref_s[k]});
        if (viol) $display("[TB] note: secret_key changed while busy (protocol violation flagged)");
        @(posedge clk);
        #1;
        check("finish_pulse", {31'd0, bus.finish}, 32'd0);
        check("idle_sel", {31'd0, bus.selector}, 32'd0);
        @(posedge clk);
        #1;
        check(hold ? "restart_sel" : "stay_idle", {31'd0, bus.selector}, {31'd0, hold});
        bus.start = 1'b0;
    endtask

    initial begin
        logic [8*KB-1:0] rk;
        logic [8*KB-1:0] rk2;
        int cyc;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.secret_key = '0;
        mem_init_req   = 1'b0;
        #13;
        check("rst_addr", {24'd0, bus.address}, 32'd0);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_wren", {31'd0, bus.wren}, 32'd0);
        check("rst_sel",  {31'd0, bus.selector}, 32'd0);
        check("rst_fin",  {31'd0, bus.finish}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_full(24'h030201, '0, 0, 24'h030201, 0);
        check("t1_w0", {16'd0, wr_log[0]}, 32'h0003);
        check("t1_w1", {16'd0, wr_log[1]}, 32'h0300);
        check("t1_w2", {16'd0, wr_log[2]}, 32'h0106);
        check("t1_w3", {16'd0, wr_log[3]}, 32'h0601);

        run_full(24'hFFFFFF, '0, 0, 24'hFFFFFF, 0);
        check("t2_w0", {16'd0, wr_log[0]}, 32'h00FF);
        check("t2_w1", {16'd0, wr_log[1]}, 32'hFF00);
        check("t2_w2", {16'd0, wr_log[2]}, 32'h0100);
        check("t2_w3", {16'd0, wr_log[3]}, 32'hFF01);

        run_full(24'h000000, '0, 0, 24'h000000, 0);
        check("t3_w0", {16'd0, wr_log[0]}, 32'h0000);
        check("t3_w1", {16'd0, wr_log[1]}, 32'h0000);

        run_full(24'h000249, '0, 0, 24'h000249, 0);

        for (int n = 0; n < 2; n++) begin
            rk = 24'($urandom);
            run_full(rk, '0, 0, rk, 0);
        end

        // Reset in the WR_I cycle of iteration 100, then a fresh full shuffle.
        init_mem();
        rk = 24'($urandom);
        @(negedge clk);
        bus.secret_key = rk;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 1 + 100*ITER_CYC + 2*(1+RD_LAT)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wri_wren", {31'd0, bus.wren}, 32'd1);
        check("wri_addr", {24'd0, bus.address}, 32'd100);
        #2;
        reset = 1'b0;
        #1;
        check("arst_addr", {24'd0, bus.address}, 32'd0);
        check("arst_data", {24'd0, bus.data}, 32'd0);
        check("arst_wren", {31'd0, bus.wren}, 32'd0);
        check("arst_sel",  {31'd0, bus.selector}, 32'd0);
        check("arst_fin",  {31'd0, bus.finish}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rk = 24'($urandom);
        run_full(rk, '0, 0, rk, 0);

        // start held high: engine re-enters the shuffle straight after DONE.
        rk = 24'($urandom);
        run_full(rk, '0, 0, rk, 1);
        do_reset();

        // Key changed one cycle after start.
        rk  = 24'($urandom);
        rk2 = ~rk;
`ifdef KSA_KEY_LATCH_EN
        run_full(rk, rk2, 1, rk, 0);
`else
        run_full(rk, rk2, 1, rk2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_shuffle_s.md
Name: ksa_shuffle_s

Overview:
RC4 key-scheduling shuffle engine, run after S-memory initialisation has completed (S[i] = i).
- Reads and writes the 256x8 S working memory through the shared memory port.
- Performs, for i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Owns the memory port mux while active via selector; reports completion to the top-level sequencer with a one-cycle finish pulse.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; key byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8], so byte 0 is the MSB byte.
- RD_LAT, 1, S-memory read latency in cycles. q is valid RD_LAT cycles after the address is presented.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, level; sampled only in IDLE.
- secret_key, in, 8*KEY_BYTES, key; MSB byte is used first.
- q, in, 8, S-memory read data.
- address, out, 8, S-memory address.
- data, out, 8, S-memory write data.
- wren, out, 1, S-memory write enable.
- selector, out, 1, high while the block owns the memory port.
- finish, out, 1, one-cycle completion pulse.

Behaviour:
Reset (async, reset=0):
- State = IDLE; i = j = 0; si/sj latches = 0.
- address = data = 0; wren = selector = finish = 0.
- Reset mid-shuffle aborts immediately. Memory contents are left partially shuffled; the sequencer must re-run init.

State machine:
- IDLE: start=1 -> RD_I, with i=0 and j=0.
- RD_I: address=i -> WAIT_I.
- WAIT_I: held RD_LAT cycles. On the last cycle, si <= q and j <= (j + q + key[i mod KEY_BYTES]) mod 256 -> RD_J.
- RD_J: address=j (the new j) -> WAIT_J.
- WAIT_J: held RD_LAT cycles. On the last cycle, sj <= q -> WR_I.
- WR_I: address=i, data=sj, wren=1 -> WR_J.
- WR_J: address=j, data=si, wren=1 -> NEXT.
- NEXT: if i==255 -> DONE; else i <= i+1 -> RD_I.
- DONE: finish=1 for exactly this cycle -> IDLE unconditionally.

Output and timing rules:
- selector = 1 in every state except IDLE and DONE.
- wren = 1 only in WR_I and WR_J; address and data are don't-care, but driven stable, elsewhere.
- Iteration length = 2*(1+RD_LAT)+3 cycles (7 at default).
- finish is asserted 1 + 256*(2*RD_LAT+5) cycles after the IDLE cycle in which start is sampled high (1793 at default).

Arithmetic:
- All 8-bit; j addition wraps mod 256.
- i mod KEY_BYTES is held as a separate counter (0..KEY_BYTES-1, wrapping); no divider.

Boundary conditions:
- i==j: WR_I then WR_J write the same address. The second write carries si, which equals the original value, so memory is unchanged.
- start held high continuously: after DONE->IDLE the block restarts on the next cycle.
- start pulses while busy are ignored.
- secret_key must be stable from start until finish, unless the optional feature is enabled.

Optional Feature:
Macro: KSA_KEY_LATCH_EN
- Defined: secret_key is captured into an internal register in the IDLE cycle where start is accepted. All iterations use the captured value; later changes to secret_key have no effect until the next start.
- Undefined: no key register; secret_key is read live every iteration, and the caller must hold it stable.

Test Plan:
1. Identity S, key=0x030201, start pulse:
   - iteration 0 writes addr 0x00 data 0x03, then addr 0x03 data 0x00.
   - iteration 1 writes addr 0x01 data 0x06, then addr 0x06 data 0x01.
2. Identity S, key=0xFFFFFF (wrap):
   - iteration 0: j=0xFF; writes addr 0x00 data 0xFF, then addr 0xFF data 0x00.
   - iteration 1: j=0xFF; writes addr 0x01 data 0x00, then addr 0xFF data 0x01.
3. Identity S, key=0x000000: iteration 0 is i==j=0, giving two writes to addr 0 with data 0x00; S[0] remains 0x00.
4. Full run, RD_LAT=1:
   - selector rises the cycle after start is sampled.
   - finish pulses once at exactly +1793 cycles, then selector=0 and the block is in IDLE.
   - final memory matches a software KSA model for key 0x000249.
5. Assert reset=0 at iteration 100 during WR_I: outputs are zero immediately (asynchronously); a new start runs a fresh 1793-cycle shuffle.
6. With KSA_KEY_LATCH_EN: change secret_key one cycle after start; final S matches the original key. Without the macro, the same stimulus is flagged as a protocol violation by the bench checker.
